// File: rtl/fpgc_dma_pkg.sv
// Shared definitions for the SDRAM line-copy DMA: register map, CTRL/STATUS
// bit positions and the copy FSM state type.
package fpgc_dma_pkg;

    localparam logic [1:0] REG_SRC   = 2'd0;
    localparam logic [1:0] REG_DST   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_GO_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_IRQ_BIT  = 1;

    // Two codes are unused; the FSM's default branch steers them back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/sdram_line_copier_regs.sv
// CPU register front-end for sdram_line_copier: decodes accesses, acks them
// one cycle later with registered read data, and owns irq_pending.
module sdram_line_copier_regs
    import fpgc_dma_pkg::*;
#(
    parameter int LINE_ADDR_BITS = 21,
    parameter int CNT_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      reg_start,
    input  logic [1:0]                reg_addr,
    input  logic [31:0]               reg_data,
    input  logic                      reg_we,
    output logic [31:0]               reg_q,
    output logic                      reg_done,
    input  logic                      busy,
    input  logic                      finish,
    input  logic [LINE_ADDR_BITS-1:0] src,
    input  logic [LINE_ADDR_BITS-1:0] dst,
    input  logic [CNT_BITS-1:0]       count,
    output logic                      src_we,
    output logic                      dst_we,
    output logic                      count_we,
    output logic                      go,
    output logic                      irq_pending
);

    logic        wr_acc;
    logic        clr;
    logic [31:0] rd_data;
    logic        unused_wdata;

    assign wr_acc       = reg_start && reg_we;
    assign unused_wdata = ^reg_data[31:2];

    // Programming registers are frozen while a copy runs; the access is still acked.
    assign src_we   = wr_acc && !busy && (reg_addr == REG_SRC);
    assign dst_we   = wr_acc && !busy && (reg_addr == REG_DST);
    assign count_we = wr_acc && !busy && (reg_addr == REG_COUNT);
    assign go       = wr_acc && !busy && (reg_addr == REG_CTRL) && reg_data[CTRL_GO_BIT];
    assign clr      = wr_acc && (reg_addr == REG_CTRL) && reg_data[CTRL_CLR_BIT];

    always_comb begin
        rd_data = '0;
        case (reg_addr)
            REG_SRC:   rd_data = 32'(src);
            REG_DST:   rd_data = 32'(dst);
            REG_COUNT: rd_data = 32'(count);
            default: begin
                rd_data[STAT_IRQ_BIT]  = irq_pending;
                rd_data[STAT_BUSY_BIT] = busy;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_done    <= 1'b0;
            reg_q       <= '0;
            irq_pending <= 1'b0;
        end else begin
            reg_done <= reg_start;
            reg_q    <= (reg_start && !reg_we) ? rd_data : '0;
            // Completion outranks a clear landing in the same cycle.
            if (finish)
                irq_pending <= 1'b1;
            else if (clr)
                irq_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_line_copier.sv
// DMA engine copying whole 256-bit lines SDRAM->SDRAM over the controller's
// cpu-side port; programmed through a start/done register port, raises irq.
module sdram_line_copier
    import fpgc_dma_pkg::*;
#(
    parameter int LINE_ADDR_BITS = 21,
    parameter int LINE_BITS      = 256,
    parameter int CNT_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      reg_start,
    input  logic [1:0]                reg_addr,
    input  logic [31:0]               reg_data,
    input  logic                      reg_we,
    output logic [31:0]               reg_q,
    output logic                      reg_done,
    output logic [LINE_ADDR_BITS-1:0] sdc_addr,
    output logic [LINE_BITS-1:0]      sdc_data,
    output logic                      sdc_we,
    output logic                      sdc_start,
    input  logic                      sdc_done,
    input  logic [LINE_BITS-1:0]      sdc_q,
    output logic                      irq
);

    dma_state_e                state_q, state_d;
    logic [LINE_ADDR_BITS-1:0] src_q, dst_q;
    logic [CNT_BITS-1:0]       cnt_q;
    logic [LINE_BITS-1:0]      line_buf;
    logic                      src_we, dst_we, count_we, go, irq_pending;
    logic                      busy, finish, sdc_ack, line_done, last_line;

    assign busy      = (state_q != ST_IDLE);
    assign finish    = (state_q == ST_FINISH);
    assign sdc_ack   = sdc_start && sdc_done;
    assign line_done = (state_q == ST_WR_WAIT) && sdc_ack;
    assign last_line = (cnt_q == CNT_BITS'(1));
    assign irq       = irq_pending;
    assign sdc_data  = sdc_we ? line_buf : '0;

    sdram_line_copier_regs #(
        .LINE_ADDR_BITS (LINE_ADDR_BITS),
        .CNT_BITS       (CNT_BITS)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_start   (reg_start),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_we      (reg_we),
        .reg_q       (reg_q),
        .reg_done    (reg_done),
        .busy        (busy),
        .finish      (finish),
        .src         (src_q),
        .dst         (dst_q),
        .count       (cnt_q),
        .src_we      (src_we),
        .dst_we      (dst_we),
        .count_we    (count_we),
        .go          (go),
        .irq_pending (irq_pending)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: state_d gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = (cnt_q == '0) ? ST_FINISH : ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (sdc_ack) state_d = ST_WR_REQ;
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: if (sdc_ack) state_d = last_line ? ST_FINISH : ST_RD_REQ;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Address counters wrap silently at 2^LINE_ADDR_BITS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else if (line_done) begin
            src_q <= src_q + 1'b1;
            dst_q <= dst_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end else begin
            if (src_we)   src_q <= reg_data[LINE_ADDR_BITS-1:0];
            if (dst_we)   dst_q <= reg_data[LINE_ADDR_BITS-1:0];
            if (count_we) cnt_q <= reg_data[CNT_BITS-1:0];
        end
    end

    // REQ states are the mandatory low-gap cycle; the request rises on leaving them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdc_start <= 1'b0;
            sdc_we    <= 1'b0;
            sdc_addr  <= '0;
        end else begin
            case (state_q)
                ST_RD_REQ: begin
                    sdc_start <= 1'b1;
                    sdc_we    <= 1'b0;
                    sdc_addr  <= src_q;
                end
                ST_RD_WAIT: if (sdc_ack) sdc_start <= 1'b0;
                ST_WR_REQ: begin
                    sdc_start <= 1'b1;
                    sdc_we    <= 1'b1;
                    sdc_addr  <= dst_q;
                end
                ST_WR_WAIT: if (sdc_ack) begin
                    sdc_start <= 1'b0;
                    sdc_we    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the line buffer is datapath storage with no reset; sdc_data masks it until a write is issued.
    always_ff @(posedge clk) begin
        if ((state_q == ST_RD_WAIT) && sdc_ack)
            line_buf <= sdc_q;
    end

endmodule
